mem_arbiter: RTL and testbench

- Shares one memory port (MemBus-style: op/addr/data request, rsp_vld/rsp_data response) among NUM_REQ cache requesters.
- Round-robin arbitration; one memory transaction in flight at a time.
- Routes each read response back to the requester that issued the read, with a timeout guard.
- Sits between the cache instances and the Mem model.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory arbiter.
// The arbiter uses the slave view. Whatever plays the requesters and the
// memory uses the master view.
interface mem_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
);
   logic [2*NUM_REQ-1:0]          req_op;
   logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rsp_vld;
   logic                          rsp_err;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic [1:0]                    mem_req_op;
   logic [ADDR_WIDTH-1:0]         mem_req_addr;
   logic [DATA_WIDTH-1:0]         mem_req_data;
   logic                          mem_rsp_vld;
   logic [DATA_WIDTH-1:0]         mem_rsp_data;

   modport slave (
      input  req_op, req_addr, req_data, mem_rsp_vld, mem_rsp_data,
      output gnt, rsp_vld, rsp_err, rsp_data, mem_req_op, mem_req_addr, mem_req_data
   );

   modport master (
      output req_op, req_addr, req_data, mem_rsp_vld, mem_rsp_data,
      input  gnt, rsp_vld, rsp_err, rsp_data, mem_req_op, mem_req_addr, mem_req_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port among NUM_REQ requesters.
// Only one transaction is in flight at a time. Each read response goes back to
// the requester that owns the read. A read with no memory response within
// TIMEOUT cycles is answered with an error response.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | sample requests, grant the next pending requester round-robin
// ST_ISSUE    | request is on mem_req_* for one cycle; requests are not sampled
// ST_WAIT_RSP | read outstanding; wait for mem_rsp_vld or the timeout
module mem_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] OP_INVALID = 2'd0;
   localparam logic [1:0] OP_READ    = 2'd1;
   localparam logic [1:0] OP_WRITE   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]     rsp_vld_q, rsp_vld_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic [1:0]             mem_req_op_q, mem_req_op_d;
   logic [ADDR_WIDTH-1:0]  mem_req_addr_q, mem_req_addr_d;
   logic [DATA_WIDTH-1:0]  mem_req_data_q, mem_req_data_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [TMR_W-1:0]       timer_q, timer_d;

   logic [NUM_REQ-1:0]     pending;
   logic                   sel_vld;
   logic [IDX_W-1:0]       sel_idx;
   logic [1:0]             sel_op;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_data;

   // Pending means a real READ or WRITE; op code 3 counts as INVALID.
   always_comb begin
      pending = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pending[i] = (bus.req_op[2*i +: 2] == OP_READ) ||
                      (bus.req_op[2*i +: 2] == OP_WRITE);
      end
   end

   // Round-robin pick: first pending index starting one past the last grant, with wrap.
   always_comb begin
      sel_vld  = 1'b0;
      sel_idx  = '0;
      sel_op   = OP_INVALID;
      sel_addr = '0;
      sel_data = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_vld && pending[i] && (((int'(last_q) + k) % NUM_REQ) == i)) begin
               sel_vld  = 1'b1;
               sel_idx  = IDX_W'(i);
               sel_op   = bus.req_op[2*i +: 2];
               sel_addr = bus.req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
               sel_data = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
         end
      end
   end

   // Next state and next register values of every output.
   always_comb begin
      state_d        = state_q;
      gnt_d          = '0;
      rsp_vld_d      = '0;
      rsp_err_d      = 1'b0;
      rsp_data_d     = rsp_data_q;
      mem_req_op_d   = OP_INVALID;
      mem_req_addr_d = mem_req_addr_q;
      mem_req_data_d = mem_req_data_q;
      owner_d        = owner_q;
      last_d         = last_q;
      timer_d        = timer_q;

      case (state_q)
         ST_IDLE: begin
            if (sel_vld) begin
               mem_req_op_d   = sel_op;
               mem_req_addr_d = sel_addr;
               mem_req_data_d = sel_data;
               gnt_d          = NUM_REQ'(1) << sel_idx;
               owner_d        = sel_idx;
               last_d         = sel_idx;
               state_d        = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // Writes are fire-and-forget. Only reads wait for a response.
            timer_d = '0;
            state_d = (mem_req_op_q == OP_READ) ? ST_WAIT_RSP : ST_IDLE;
         end

         ST_WAIT_RSP: begin
            if (bus.mem_rsp_vld) begin
               rsp_vld_d  = NUM_REQ'(1) << owner_q;
               rsp_data_d = bus.mem_rsp_data;
               state_d    = ST_IDLE;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               rsp_vld_d  = NUM_REQ'(1) << owner_q;
               rsp_err_d  = 1'b1;
               rsp_data_d = '0;
               state_d    = ST_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         gnt_q          <= '0;
         rsp_vld_q      <= '0;
         rsp_err_q      <= 1'b0;
         rsp_data_q     <= '0;
         mem_req_op_q   <= OP_INVALID;
         mem_req_addr_q <= '0;
         mem_req_data_q <= '0;
         owner_q        <= '0;
         last_q         <= IDX_W'(NUM_REQ - 1);
         timer_q        <= '0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         rsp_vld_q      <= rsp_vld_d;
         rsp_err_q      <= rsp_err_d;
         rsp_data_q     <= rsp_data_d;
         mem_req_op_q   <= mem_req_op_d;
         mem_req_addr_q <= mem_req_addr_d;
         mem_req_data_q <= mem_req_data_d;
         owner_q        <= owner_d;
         last_q         <= last_d;
         timer_q        <= timer_d;
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.rsp_vld      = rsp_vld_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.mem_req_op   = mem_req_op_q;
   assign bus.mem_req_addr = mem_req_addr_q;
   assign bus.mem_req_data = mem_req_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two requesters and a one-cycle memory model.
module tb_mem_arbiter;
   localparam logic [1:0] INV = 2'd0;
   localparam logic [1:0] RD  = 2'd1;
   localparam logic [1:0] WR  = 2'd2;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mem_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();

   mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(6), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: writes land on the edge, reads answer one cycle later.
   logic [7:0] mem [64];
   logic       mem_vld_m;
   logic [7:0] mem_data_m;
   logic       mem_en;
   logic       stray;

   always @(posedge clk) begin
      if (!rst) begin
         mem_vld_m  <= 1'b0;
         mem_data_m <= 8'h00;
         mem[6'h01] <= 8'h11;
         mem[6'h02] <= 8'h22;
         mem[6'h3F] <= 8'h5C;
      end else begin
         mem_vld_m  <= (bus.mem_req_op == RD);
         mem_data_m <= mem[bus.mem_req_addr];
         if (bus.mem_req_op == WR) mem[bus.mem_req_addr] <= bus.mem_req_data;
      end
   end

   assign bus.mem_rsp_vld  = (mem_vld_m & mem_en) | stray;
   assign bus.mem_rsp_data = mem_data_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic set_req(input int idx, input logic [1:0] op, input logic [5:0] a, input logic [7:0] d);
      bus.req_op[2*idx +: 2]   = op;
      bus.req_addr[6*idx +: 6] = a;
      bus.req_data[8*idx +: 8] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.req_op   = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      mem_en       = 1'b1;
      stray        = 1'b0;
      repeat (3) nxt();

      check("rst_gnt",      32'(bus.gnt), 32'h0);
      check("rst_rsp_vld",  32'(bus.rsp_vld), 32'h0);
      check("rst_rsp_err",  32'(bus.rsp_err), 32'h0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
      check("rst_mem_op",   32'(bus.mem_req_op), 32'h0);
      check("rst_mem_addr", 32'(bus.mem_req_addr), 32'h0);
      check("rst_mem_data", 32'(bus.mem_req_data), 32'h0);
      rst = 1'b1;

      // Write then read back through requester 0.
      set_req(0, WR, 6'h05, 8'hA5);
      nxt();
      check("t1_wr_gnt",  32'(bus.gnt), 32'h1);
      check("t1_wr_op",   32'(bus.mem_req_op), 32'h2);
      check("t1_wr_addr", 32'(bus.mem_req_addr), 32'h05);
      check("t1_wr_data", 32'(bus.mem_req_data), 32'hA5);
      set_req(0, RD, 6'h05, 8'h00);
      nxt();
      check("t1_wr_gnt_off", 32'(bus.gnt), 32'h0);
      check("t1_wr_op_off",  32'(bus.mem_req_op), 32'h0);
      nxt();
      check("t1_rd_gnt",  32'(bus.gnt), 32'h1);
      check("t1_rd_op",   32'(bus.mem_req_op), 32'h1);
      check("t1_rd_addr", 32'(bus.mem_req_addr), 32'h05);
      set_req(0, INV, 6'h00, 8'h00);
      nxt();
      check("t1_rsp_early", 32'(bus.rsp_vld), 32'h0);
      nxt();
      check("t1_rsp_vld",  32'(bus.rsp_vld), 32'h1);
      check("t1_rsp_err",  32'(bus.rsp_err), 32'h0);
      check("t1_rsp_data", 32'(bus.rsp_data), 32'hA5);
      nxt();
      check("t1_rsp_pulse", 32'(bus.rsp_vld), 32'h0);

      // Two simultaneous reads after reset: requester 0 first, then 1.
      rst = 1'b0;
      repeat (2) nxt();
      rst = 1'b1;
      set_req(0, RD, 6'h01, 8'h00);
      set_req(1, RD, 6'h02, 8'h00);
      nxt();
      check("t2_gnt0",  32'(bus.gnt), 32'h1);
      check("t2_addr0", 32'(bus.mem_req_addr), 32'h01);
      set_req(0, INV, 6'h00, 8'h00);
      nxt();
      check("t2_gnt_wait", 32'(bus.gnt), 32'h0);
      nxt();
      check("t2_rsp0_vld",  32'(bus.rsp_vld), 32'h1);
      check("t2_rsp0_data", 32'(bus.rsp_data), 32'h11);
      check("t2_no_gnt1_yet", 32'(bus.gnt), 32'h0);
      nxt();
      check("t2_gnt1",     32'(bus.gnt), 32'h2);
      check("t2_rsp_off",  32'(bus.rsp_vld), 32'h0);
      check("t2_addr1",    32'(bus.mem_req_addr), 32'h02);
      set_req(1, INV, 6'h00, 8'h00);
      nxt();
      check("t2_rsp1_early", 32'(bus.rsp_vld), 32'h0);
      nxt();
      check("t2_rsp1_vld",  32'(bus.rsp_vld), 32'h2);
      check("t2_rsp1_data", 32'(bus.rsp_data), 32'h22);

      // Continuous writes from both: alternate grants, one every two cycles.
      set_req(0, WR, 6'h10, 8'h30);
      set_req(1, WR, 6'h20, 8'h40);
      for (int g = 0; g < 8; g++) begin
         nxt();
         check("t3_gnt",  32'(bus.gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
         check("t3_addr", 32'(bus.mem_req_addr), (g % 2 == 0) ? 32'h10 : 32'h20);
         nxt();
         check("t3_gap", 32'(bus.gnt), 32'h0);
      end
      set_req(0, INV, 6'h00, 8'h00);
      set_req(1, INV, 6'h00, 8'h00);
      nxt();

      // Read with a silent memory: error response after TIMEOUT cycles.
      mem_en = 1'b0;
      set_req(0, RD, 6'h01, 8'h00);
      nxt();
      check("t4_gnt", 32'(bus.gnt), 32'h1);
      set_req(0, INV, 6'h00, 8'h00);
      for (int k = 1; k <= 15; k++) begin
         nxt();
         check("t4_no_rsp", 32'(bus.rsp_vld), 32'h0);
      end
      nxt();
      check("t4_to_vld",  32'(bus.rsp_vld), 32'h1);
      check("t4_to_err",  32'(bus.rsp_err), 32'h1);
      check("t4_to_data", 32'(bus.rsp_data), 32'h0);
      stray = 1'b1;
      nxt();
      stray = 1'b0;
      check("t4_stray_vld", 32'(bus.rsp_vld), 32'h0);
      check("t4_stray_err", 32'(bus.rsp_err), 32'h0);
      check("t4_stray_gnt", 32'(bus.gnt), 32'h0);
      nxt();
      check("t4_stray_vld2", 32'(bus.rsp_vld), 32'h0);

      // Reset in the middle of a read wait.
      set_req(0, RD, 6'h05, 8'h00);
      nxt();
      check("t5_gnt0", 32'(bus.gnt), 32'h1);
      set_req(0, INV, 6'h00, 8'h00);
      nxt();
      nxt();
      #2 rst = 1'b0;
      #1;
      check("t5_async_gnt",  32'(bus.gnt), 32'h0);
      check("t5_async_vld",  32'(bus.rsp_vld), 32'h0);
      check("t5_async_op",   32'(bus.mem_req_op), 32'h0);
      check("t5_async_addr", 32'(bus.mem_req_addr), 32'h0);
      nxt();
      mem_en = 1'b1;
      rst    = 1'b1;
      set_req(1, RD, 6'h02, 8'h00);
      nxt();
      check("t5_gnt1",  32'(bus.gnt), 32'h2);
      check("t5_stale", 32'(bus.rsp_vld), 32'h0);
      set_req(1, INV, 6'h00, 8'h00);
      nxt();
      check("t5_rsp_early", 32'(bus.rsp_vld), 32'h0);
      nxt();
      check("t5_rsp_vld",  32'(bus.rsp_vld), 32'h2);
      check("t5_rsp_data", 32'(bus.rsp_data), 32'h22);

      // Op code 3 is never granted.
      set_req(0, 2'd3, 6'h07, 8'h99);
      set_req(1, RD, 6'h3F, 8'h00);
      nxt();
      check("t6_gnt1", 32'(bus.gnt), 32'h2);
      check("t6_op",   32'(bus.mem_req_op), 32'h1);
      check("t6_addr", 32'(bus.mem_req_addr), 32'h3F);
      set_req(1, INV, 6'h00, 8'h00);
      nxt();
      check("t6_gnt_off", 32'(bus.gnt), 32'h0);
      nxt();
      check("t6_rsp_vld",  32'(bus.rsp_vld), 32'h2);
      check("t6_rsp_data", 32'(bus.rsp_data), 32'h5C);
      for (int k = 0; k < 4; k++) begin
         nxt();
         check("t6_op3_no_gnt", 32'(bus.gnt), 32'h0);
         check("t6_op3_no_op",  32'(bus.mem_req_op), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
